// File: rtl/lock_input_conditioner_pkg.sv
// Shared constants and types for the combination-lock input front-end.
// Channel indices fix where each raw input lives in the per-channel arrays.
package lock_input_conditioner_pkg;

  localparam int DEB_CYCLES_DEFAULT  = 100000;
  localparam int DEB_CYCLES_SIM      = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam int NUM_CH    = 6;
  localparam int SW_A      = 0;
  localparam int SW_B      = 1;
  localparam int SW_C      = 2;
  localparam int SW_D      = 3;
  localparam int CH_ENLOCK = 4;
  localparam int CH_ENCMP  = 5;

  // rise_next is the combinational "accepting a 0->1 at this edge" flag;
  // rise is its registered form, high while level first reads 1.
  typedef struct packed {
    logic level;
    logic rise;
    logic rise_next;
    logic unstable;
  } ch_out_t;

endpackage

// File: rtl/lock_input_conditioner_debounce_channel.sv
// One conditioned input: synchroniser, debounce counter, stable level,
// registered rise strobe and a mid-debounce flag.
module debounce_channel
  import lock_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    raw,
  output ch_out_t ch_out
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   stable_r;
  logic                   rise_r;
  logic                   sync_s;
  logic                   unstable_s;
  logic                   accept_s;
  logic                   rise_next_s;

  assign sync_s      = sync_r[SYNC_STAGES-1];
  assign unstable_s  = sync_s ^ stable_r;
  assign accept_s    = unstable_s & (cnt_r == CNT_LAST);
  assign rise_next_s = accept_s & sync_s;

  // Synchroniser shift, debounce counting and level acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      stable_r <= 1'b0;
      rise_r   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      rise_r <= rise_next_s;
      if (accept_s) begin
        stable_r <= sync_s;
        cnt_r    <= {CNT_W{1'b0}};
      end else if (unstable_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign ch_out = {stable_r, rise_r, rise_next_s, unstable_s};

endmodule

// File: rtl/lock_input_conditioner.sv
// Lock input front-end: six debounced channels plus the compare strobe,
// which is deferred while any code switch is still settling.
module lock_input_conditioner
  import lock_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  input  logic       enlock_raw,
  input  logic       encmp_raw,
  output logic [3:0] sw_clean,
  output logic       enlock_lvl,
  output logic       enlock_rise,
  output logic       encmp_lvl,
  output logic       encmp_pulse,
  output logic       busy
);

  logic [NUM_CH-1:0] raw_s;
  ch_out_t           ch_s [NUM_CH];
  logic              busy_s;
  logic              fire_s;
  logic              pending_r;
  logic              encmp_pulse_r;

  // Route raw inputs onto their channel slots.
  always_comb begin
    raw_s            = {NUM_CH{1'b0}};
    raw_s[SW_A]      = sw_raw[0];
    raw_s[SW_B]      = sw_raw[1];
    raw_s[SW_C]      = sw_raw[2];
    raw_s[SW_D]      = sw_raw[3];
    raw_s[CH_ENLOCK] = enlock_raw;
    raw_s[CH_ENCMP]  = encmp_raw;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_s[ch]),
      .ch_out(ch_s[ch])
    );
  end

  assign busy_s = ch_s[SW_A].unstable | ch_s[SW_B].unstable |
                  ch_s[SW_C].unstable | ch_s[SW_D].unstable;

  // The previous-pulse term keeps two pending requests from producing
  // back-to-back strobes.
  assign fire_s = pending_r & ~busy_s & ~encmp_pulse_r;

  // Pending compare request and its gated strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r     <= 1'b0;
      encmp_pulse_r <= 1'b0;
    end else begin
      pending_r     <= ch_s[CH_ENCMP].rise_next | (pending_r & ~fire_s);
      encmp_pulse_r <= fire_s;
    end
  end

  assign sw_clean    = {ch_s[SW_D].level, ch_s[SW_C].level,
                        ch_s[SW_B].level, ch_s[SW_A].level};
  assign enlock_lvl  = ch_s[CH_ENLOCK].level;
  assign enlock_rise = ch_s[CH_ENLOCK].rise;
  assign encmp_lvl   = ch_s[CH_ENCMP].level;
  assign encmp_pulse = encmp_pulse_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Self-checking bench: a sample-history reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_lock_input_conditioner;
  import lock_input_conditioner_pkg::*;

  localparam int DEB = DEB_CYCLES_SIM;
  localparam int SYN = 2;
  localparam int HD  = SYN + DEB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic       enlock_raw = 1'b0;
  logic       encmp_raw = 1'b0;
  logic [3:0] sw_clean;
  logic       enlock_lvl, enlock_rise, encmp_lvl, encmp_pulse, busy;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // h[ch][0] is the raw value sampled at the latest edge, h[ch][1] the one before, ...
  bit h [NUM_CH][HD];
  bit m_stable [NUM_CH];
  bit m_pending, m_pulse, m_enlock_rise;

  lock_input_conditioner #(.DEB_CYCLES(DEB), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .enlock_raw(enlock_raw),
    .encmp_raw(encmp_raw), .sw_clean(sw_clean), .enlock_lvl(enlock_lvl),
    .enlock_rise(enlock_rise), .encmp_lvl(encmp_lvl), .encmp_pulse(encmp_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit raw_of(int ch);
    if (ch < 4) return sw_raw[ch];
    else if (ch == CH_ENLOCK) return enlock_raw;
    else return encmp_raw;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_stable[c] = 1'b0;
      for (int k = 0; k < HD; k++) h[c][k] = 1'b0;
    end
    m_pending = 1'b0; m_pulse = 1'b0; m_enlock_rise = 1'b0;
  endtask

  // A channel takes a new level once its last DEB synchronised samples all
  // disagree with the current level; synchronised sample = raw from SYN edges back.
  task automatic model_edge();
    bit busy_pre, fire, cmp_rise, all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    busy_pre = 1'b0;
    for (int c = 0; c < 4; c++) if (h[c][SYN-1] != m_stable[c]) busy_pre = 1'b1;
    fire = m_pending && !busy_pre && !m_pulse;
    cmp_rise = 1'b0;
    m_enlock_rise = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      all_diff = 1'b1;
      for (int k = SYN - 1; k <= SYN + DEB - 2; k++)
        if (h[c][k] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[c] = !m_stable[c];
        if (c == CH_ENCMP && m_stable[c]) cmp_rise = 1'b1;
        if (c == CH_ENLOCK && m_stable[c]) m_enlock_rise = 1'b1;
      end
    end
    m_pulse = fire;
    m_pending = cmp_rise || (m_pending && !fire);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = HD - 1; k > 0; k--) h[c][k] = h[c][k-1];
      h[c][0] = raw_of(c);
    end
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_sw;
    bit exp_busy;
    exp_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_sw[c] = m_stable[c];
      if (h[c][SYN-1] != m_stable[c]) exp_busy = 1'b1;
    end
    chk("sw_clean", sw_clean, exp_sw);
    chk("enlock_lvl", {3'b000, enlock_lvl}, {3'b000, m_stable[CH_ENLOCK]});
    chk("enlock_rise", {3'b000, enlock_rise}, {3'b000, m_enlock_rise});
    chk("encmp_lvl", {3'b000, encmp_lvl}, {3'b000, m_stable[CH_ENCMP]});
    chk("encmp_pulse", {3'b000, encmp_pulse}, {3'b000, m_pulse});
    chk("busy", {3'b000, busy}, {3'b000, exp_busy});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (encmp_pulse === 1'b1) pulses++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Alternate bouncing between sw[2] and sw[1] so busy never drops, with
  // encmp_raw high inside [on1,off1) and [on2,off2).
  task automatic run_alt(int cycles, int on1, int off1, int on2, int off2);
    for (int c = 0; c < cycles; c++) begin
      sw_raw = (((c / 3) % 2) == 0) ? 4'b1111 : 4'b1001;
      encmp_raw = ((c >= on1) && (c < off1)) || ((c >= on2) && (c < off2));
      step();
    end
  endtask

  initial begin
    model_reset();
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // 1: clean step 0000 -> 1010
    sw_raw = 4'b1010;
    step();
    chk("t1_busy_e1", {3'b000, busy}, 4'b0000);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("t1_busy_mid", {3'b000, busy}, 4'b0001);
      chk("t1_sw_pre", sw_clean, 4'b0000);
    end
    step();
    chk("t1_sw_at6", sw_clean, 4'b1010);
    chk("t1_busy_at6", {3'b000, busy}, 4'b0000);
    steps(3);

    // 2: bounce rejection on sw[0]
    for (int b = 0; b < 4; b++) begin
      sw_raw[0] = ~b[0];
      steps(3);
      chk("t2_bounce", sw_clean, 4'b1010);
    end
    sw_raw[0] = 1'b1;
    steps(5);
    chk("t2_sw_pre", sw_clean, 4'b1010);
    step();
    chk("t2_sw_at6", sw_clean, 4'b1011);
    steps(4);

    // 3: quiet compare
    pulses = 0;
    encmp_raw = 1'b1;
    steps(5);
    chk("t3_lvl_pre", {3'b000, encmp_lvl}, 4'b0000);
    step();
    chk("t3_lvl_at6", {3'b000, encmp_lvl}, 4'b0001);
    chk("t3_pulse_at6", {3'b000, encmp_pulse}, 4'b0000);
    step();
    chk("t3_pulse_at7", {3'b000, encmp_pulse}, 4'b0001);
    steps(12);
    chk("t3_pulse_count", pulses[3:0], 4'd1);
    encmp_raw = 1'b0;
    steps(8);

    // 4: deferred compare, button released before switches settle
    pulses = 0;
    run_alt(24, 1, 10, 99, 99);
    chk("t4_no_pulse_while_busy", pulses[3:0], 4'd0);
    sw_raw = 4'b1011;
    steps(12);
    chk("t4_pulse_count", pulses[3:0], 4'd1);

    // 5: two debounced rises merge while busy
    pulses = 0;
    run_alt(36, 1, 9, 17, 25);
    sw_raw = 4'b1011;
    encmp_raw = 1'b0;
    steps(14);
    chk("t5_pulse_count", pulses[3:0], 4'd1);

    // 6: async reset with pending set and counters mid-count
    run_alt(10, 1, 99, 99, 99);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_sw", sw_clean, 4'b0000);
    chk("t6_rst_lvl", {2'b00, encmp_lvl, enlock_lvl}, 4'b0000);
    chk("t6_rst_busy", {3'b000, busy}, 4'b0000);
    compare_all();
    sw_raw = 4'b0000; encmp_raw = 1'b0; enlock_raw = 1'b0;
    steps(3);
    rst_n = 1'b1;
    pulses = 0;
    steps(20);
    chk("t6_no_pulse", pulses[3:0], 4'd0);
    enlock_raw = 1'b1;
    steps(5);
    chk("t6_rise_pre", {3'b000, enlock_rise}, 4'b0000);
    step();
    chk("t6_rise_at6", {2'b00, enlock_lvl, enlock_rise}, 4'b0011);
    step();
    chk("t6_rise_after", {3'b000, enlock_rise}, 4'b0000);

    // Randomized stimulus with occasional mid-run resets
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 9) < 2) sw_raw[c] = ~sw_raw[c];
      if ($urandom_range(0, 9) < 2) enlock_raw = ~enlock_raw;
      if ($urandom_range(0, 9) < 2) encmp_raw = ~encmp_raw;
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
